// File: rtl/tree_sched_pkg.sv
// Shared definitions for the tree-walk scheduler.
//   - node field placement helpers (leaf flag, child2, child1)
//   - null child pointer value
//   - scheduler FSM state encoding
package tree_sched_pkg;

  // child1 occupies the lowest AW bits of a node word
  localparam int unsigned CHILD1_LSB = 0;

  // child pointer value meaning "no child"; address 0 can only be a root
  localparam int unsigned NULL_ADDR  = 0;

  // child2 sits directly above child1
  function automatic int unsigned child2_lsb(input int unsigned aw);
    return aw;
  endfunction

  // leaf flag is the top bit of the node word
  function automatic int unsigned leaf_bit(input int unsigned node_w);
    return node_w - 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DISPATCH,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/sched_lifo.sv
// Pending-address LIFO for the tree-walk scheduler.
// Ports:
//   clk, reset_n   : clock, async active-low reset (clears the stack pointer)
//   push_i         : push push_data_i (ignored when full)
//   pop_i          : drop the top entry (ignored when empty)
//   push_data_i    : address to push
//   top_o          : current top entry, 0 when empty
//   empty_o/full_o : occupancy flags
module sched_lifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SP_W  = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign empty_o = (sp_q == '0);
  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign top_idx = IDX_W'(sp_q - 1'b1);
  assign wr_idx  = IDX_W'(sp_q);
  assign top_o   = empty_o ? '0 : stack_q[top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp_q <= '0;
    end else if (push_i && !full_o) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  // storage needs no reset: entries are only read below the stack pointer
  always_ff @(posedge clk) begin
    if (push_i && !full_o) begin
      stack_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/tree_walk_sched.sv
// Depth-first tree-walk scheduler. Fetches nodes from node memory, sends
// internal nodes round-robin to N_PE lanes and leaf nodes to the result store.
// Right subtrees wait on a LIFO; pushes onto a full LIFO are dropped and
// flagged on overflow.
// Ports:
//   clk, reset_n                      : clock, async active-low reset
//   start, root_addr                  : begin a walk at root_addr (ignored while busy)
//   mem_rd_en, mem_rd_addr            : node memory read request
//   mem_rd_data                       : node word, valid 1 cycle after mem_rd_en
//   pe_valid, pe_ready, pe_node       : one-hot lane dispatch handshake + payload
//   leaf_valid, leaf_ready, leaf_node : leaf emission handshake + payload
//   busy, done, overflow, node_count  : walk status
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | waiting for start
// ST_FETCH    | mem_rd_en high for one cycle at the current address
// ST_WAIT     | capture read data, prepare the dispatch
// ST_DISPATCH | hold pe_valid or leaf_valid until accepted, pick next node
// ST_DONE     | walk finished; behaves like idle and falls back to it
module tree_walk_sched
  import tree_sched_pkg::*;
#(
  parameter int unsigned NODE_W      = 222,
  parameter int unsigned AW          = 10,
  parameter int unsigned N_PE        = 4,
  parameter int unsigned STACK_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [AW-1:0]     root_addr,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_rd_addr,
  input  logic [NODE_W-1:0] mem_rd_data,
  output logic [N_PE-1:0]   pe_valid,
  input  logic [N_PE-1:0]   pe_ready,
  output logic [NODE_W-1:0] pe_node,
  output logic              leaf_valid,
  input  logic              leaf_ready,
  output logic [NODE_W-1:0] leaf_node,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [AW:0]       node_count
);

  localparam int unsigned PTR_W    = (N_PE > 1) ? $clog2(N_PE) : 1;
  localparam int unsigned LEAF_BIT = leaf_bit(NODE_W);
  localparam int unsigned C2_LSB   = child2_lsb(AW);

  sched_state_e      state_q;
  logic [NODE_W-1:0] node_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  grant_idx_q;
  logic              mem_rd_en_q;
  logic [AW-1:0]     mem_rd_addr_q;
  logic [N_PE-1:0]   pe_valid_q;
  logic              leaf_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;
  logic [AW:0]       node_count_q;

  // round-robin arbiter
  logic              grant_found_d;
  logic [PTR_W-1:0]  grant_idx_d;
  logic [N_PE-1:0]   grant_oh_d;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  ptr_inc;

  // node decode and walk control
  logic              is_leaf;
  logic [AW-1:0]     child1;
  logic [AW-1:0]     child2;
  logic              has_c1;
  logic              has_c2;
  logic              xfer_d;
  logic              branch_end;
  logic              push_req;
  logic              lifo_push;
  logic              lifo_pop;
  logic              walk_end;
  logic [AW-1:0]     next_addr_d;
  logic [AW-1:0]     lifo_top;
  logic              lifo_empty;
  logic              lifo_full;

  always_comb begin
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    grant_oh_d    = '0;
    cand          = '0;
    for (int k = 0; k < N_PE; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % N_PE);
      if (!grant_found_d && pe_ready[cand]) begin
        grant_found_d    = 1'b1;
        grant_idx_d      = cand;
        grant_oh_d[cand] = 1'b1;
      end
    end
  end

  assign ptr_inc = (grant_idx_q == PTR_W'(N_PE - 1)) ? '0 : grant_idx_q + 1'b1;

  assign is_leaf = node_q[LEAF_BIT];
  assign child1  = node_q[CHILD1_LSB +: AW];
  assign child2  = node_q[C2_LSB +: AW];
  assign has_c1  = (child1 != AW'(NULL_ADDR));
  assign has_c2  = (child2 != AW'(NULL_ADDR));

  assign xfer_d = (state_q == ST_DISPATCH) &&
                  (is_leaf ? leaf_valid_q && leaf_ready : |(pe_valid_q & pe_ready));

  // leaf or childless internal: the current branch is exhausted
  assign branch_end = is_leaf || (!has_c1 && !has_c2);
  assign push_req   = xfer_d && !is_leaf && has_c1 && has_c2;
  assign lifo_push  = push_req && !lifo_full;
  assign lifo_pop   = xfer_d && branch_end && !lifo_empty;
  assign walk_end   = xfer_d && branch_end && lifo_empty;

  always_comb begin
    next_addr_d = lifo_top;
    if (!is_leaf && has_c1) begin
      next_addr_d = child1;
    end else if (!is_leaf && has_c2) begin
      next_addr_d = child2;
    end
  end

  sched_lifo #(
    .WIDTH (AW),
    .DEPTH (STACK_DEPTH)
  ) u_lifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (lifo_push),
    .pop_i       (lifo_pop),
    .push_data_i (child2),
    .top_o       (lifo_top),
    .empty_o     (lifo_empty),
    .full_o      (lifo_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      node_q        <= '0;
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      pe_valid_q    <= '0;
      leaf_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overflow_q    <= 1'b0;
      node_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start) begin
            done_q        <= 1'b0;
            overflow_q    <= 1'b0;
            node_count_q  <= '0;
            busy_q        <= 1'b1;
            mem_rd_en_q   <= 1'b1;
            mem_rd_addr_q <= root_addr;
            state_q       <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= ST_WAIT;
        end

        ST_WAIT: begin
          node_q  <= mem_rd_data;
          state_q <= ST_DISPATCH;
          // decide from the incoming word so valid can rise on the first dispatch cycle
          if (mem_rd_data[LEAF_BIT]) begin
            leaf_valid_q <= 1'b1;
          end else if (grant_found_d) begin
            pe_valid_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
          end
        end

        ST_DISPATCH: begin
          if (xfer_d) begin
            pe_valid_q   <= '0;
            leaf_valid_q <= 1'b0;
            if (!is_leaf) begin
              ptr_q <= ptr_inc;
            end
            if (node_count_q != '1) begin
              node_count_q <= node_count_q + 1'b1;
            end
            if (push_req && lifo_full) begin
              overflow_q <= 1'b1;
            end
            if (walk_end) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              mem_rd_en_q   <= 1'b1;
              mem_rd_addr_q <= next_addr_d;
              state_q       <= ST_FETCH;
            end
          end else if (!is_leaf && (pe_valid_q == '0) && grant_found_d) begin
            // no lane was ready earlier; once granted the lane is frozen
            pe_valid_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign pe_valid    = pe_valid_q;
  assign pe_node     = node_q;
  assign leaf_valid  = leaf_valid_q;
  assign leaf_node   = node_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign node_count  = node_count_q;

endmodule

// File: doc/tree_walk_sched.md
# tree_walk_sched

Parametrised depth-first tree-walk scheduler for the simulation datapath. It fetches tree nodes from the node memory, dispatches internal nodes round-robin to `N_PE` processing lanes over a valid/ready handshake, and emits leaf nodes to the result store. Pending right subtrees are held on an internal LIFO with overflow detection. It sits between the tree memory and the PE array, in the role of the fixed 9-PE scheduler it generalises.

## Interface
- `NODE_W`, 222: node word width.
- `AW`, 10: node address width. Address 0 is the root slot; a child pointer of 0 means "no child".
- `N_PE`, 4: number of PE lanes, ≥1.
- `STACK_DEPTH`, 32: pending-node LIFO depth, power of 2.
- Node fields: `[NODE_W-1]` = leaf flag, `[2*AW-1:AW]` = child2, `[AW-1:0]` = child1.

Ports (all control outputs registered):
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a walk at `root_addr`. Ignored while `busy`.
- `root_addr` in AW: first node fetched.
- `mem_rd_en` out 1: node memory read strobe.
- `mem_rd_addr` out AW: read address.
- `mem_rd_data` in NODE_W: read data, valid exactly 1 cycle after `mem_rd_en`.
- `pe_valid` out N_PE: one-hot dispatch valid.
- `pe_ready` in N_PE: per-lane ready.
- `pe_node` out NODE_W: shared dispatch payload.
- `leaf_valid` out 1: leaf record valid.
- `leaf_ready` in 1: leaf consumer ready.
- `leaf_node` out NODE_W: leaf payload.
- `busy` out 1: walk in progress.
- `done` out 1: walk finished. Level signal, held until the next accepted `start`.
- `overflow` out 1: sticky. Set when a push hits a full LIFO; cleared on `start`.
- `node_count` out AW+1: nodes dispatched plus leaves emitted in the current walk.

## Operation
- Reset values: every output 0, FSM in IDLE, LIFO empty, round-robin pointer 0.
- FSM states are IDLE, FETCH, WAIT, DISPATCH, DONE.
- IDLE: on `start`, clear `done`, `overflow` and `node_count`. Latch `root_addr` as the current address and go to FETCH.
- FETCH: drive `mem_rd_en`=1 with `mem_rd_addr`=current address for exactly 1 cycle, then go to WAIT.
- WAIT: register `mem_rd_data` into the node register, then go to DISPATCH.
- DISPATCH, leaf node: hold `leaf_valid` and `leaf_node` until `leaf_valid && leaf_ready`. Leaf nodes are never sent to PE lanes.
- DISPATCH, internal node: grant the lowest-index ready lane at or after the pointer (modulo N_PE). Assert that lane's `pe_valid` bit with `pe_node`. The transfer completes in the cycle `pe_valid & pe_ready` is non-zero. The pointer then moves to grant+1 mod N_PE.
- Grant stability: the grant is fixed once `pe_valid` asserts. It must not move to another lane even if a different lane becomes ready.
- On completion, increment `node_count`, saturating at all-ones. Then choose the next address:
  - Internal node, child1≠0 and child2≠0: push child2, next = child1.
  - Internal node, only child1≠0: next = child1.
  - Internal node, only child2≠0: next = child2, no push.
  - Leaf, or internal with no children: pop if the LIFO is non-empty and go to FETCH with the popped address. If the LIFO is empty, go to DONE.
- Push onto a full LIFO: drop the entry, set `overflow`, continue the walk.
- DONE: `busy`=0, `done`=1. Return to IDLE in the same cycle. A `start` in DONE/IDLE restarts.
- `busy`=1 in FETCH, WAIT and DISPATCH.
- Asserting `reset_n`=0 mid-walk immediately clears all state. No output is retained.

## Timing
- Minimum 3 cycles per node (FETCH, WAIT, DISPATCH with the handshake accepted on its first cycle). Each stalled DISPATCH cycle adds 1.
- `start` at edge t gives `mem_rd_en`=1 in cycle t+1.
- Last leaf accepted at edge t (LIFO empty) gives `done`=1 from t+1.
- `pe_valid` and `leaf_valid` drop in the cycle after acceptance. They never assert simultaneously.
- Push and pop never occur in the same cycle.

## Structure
- Shared package `tree_sched_pkg`: node field offset constants, null-address constant, FSM state enum.
- Sub-module `sched_lifo` (parameters width AW, depth STACK_DEPTH): push, pop, top, empty, full; registered pointer.
- The round-robin arbiter stays inline.

## Test plan
- Root at 0 is a leaf, `leaf_ready`=1: `leaf_valid` for 1 cycle, `done` 4 cycles after `start`, `node_count`=1, `pe_valid` never asserts.
- Full tree 0→(1,2), with nodes 1 and 2 as leaves: node 0 dispatched to lane 0, leaves emitted in order 1 then 2, `node_count`=3, `overflow`=0.
- Backpressure: `pe_ready`=0 for 5 cycles, then lane 2 only: `pe_valid`=4'b0100 held stable and `pe_node` unchanged, completing 1 cycle after `pe_ready[2]` rises.
- Round-robin: all lanes ready across 6 internal nodes: grants go to lanes 0,1,2,3,0,1.
- `STACK_DEPTH`=2, left-deep tree of depth 4 with right children: `overflow`=1, walk still reaches `done`, dropped subtrees are not emitted.
- `reset_n` pulled low during DISPATCH: all outputs 0 immediately. After release, a new `start` walks correctly from `root_addr`.
